// File: rtl/act_buffer_nbank_if.sv
// Bundle of the producer (DMA write/commit) and consumer (array read/release) sides
// of the N-bank activation buffer; the buffer connects as slave, the fabric as master.
interface act_buffer_nbank_if #(
    parameter int unsigned TM         = 8,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned NUM_BANKS  = 3
);
    localparam int unsigned BW = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned CW = $clog2(NUM_BANKS + 1);

    // Producer side
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [TM*8-1:0]       wr_data;
    logic [TM-1:0]         wr_mask;
    logic                  wr_commit;
    logic [ADDR_WIDTH:0]   wr_len;
    logic                  wr_ready;
    logic [BW-1:0]         wr_bank;

    // Consumer side
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_release;
    logic                  rd_valid;
    logic [BW-1:0]         rd_bank;
    logic [ADDR_WIDTH:0]   rd_len;
    logic [TM*8-1:0]       a_vec;
    logic                  a_valid;
    logic [CW-1:0]         full_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, wr_mask, wr_commit, wr_len,
        output rd_en, rd_addr, rd_release,
        input  wr_ready, wr_bank, rd_valid, rd_bank, rd_len, a_vec, a_valid, full_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_mask, wr_commit, wr_len,
        input  rd_en, rd_addr, rd_release,
        output wr_ready, wr_bank, rd_valid, rd_bank, rd_len, a_vec, a_valid, full_cnt
    );
endinterface

// File: rtl/act_buffer_nbank.sv
// N-bank ring of activation SRAM banks: hardware-owned write/read pointers and full count.
// Optional macro ACT_BUF_OUTREG_EN adds a second output register stage (read latency 2).
module act_buffer_nbank #(
    parameter int unsigned TM         = 8,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned NUM_BANKS  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    act_buffer_nbank_if.slave    bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned DW    = TM * 8;
    localparam int unsigned BW    = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned CW    = $clog2(NUM_BANKS + 1);

    localparam logic [BW-1:0]       LastBank  = BW'(NUM_BANKS - 1);
    localparam logic [CW-1:0]       NumBanksC = CW'(NUM_BANKS);
    localparam logic [ADDR_WIDTH:0] LenMax    = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DW-1:0]       r_mem [NUM_BANKS][DEPTH];
    logic [ADDR_WIDTH:0] r_len [NUM_BANKS];
    logic [BW-1:0]       r_wp;
    logic [BW-1:0]       r_rp;
    logic [CW-1:0]       r_full_cnt;
    logic [DW-1:0]       r_a_vec;
    logic                r_a_valid;

    logic                w_wr_ready;
    logic                w_rd_valid;
    logic                w_wr_acc;
    logic                w_commit_acc;
    logic                w_rd_acc;
    logic                w_rel_acc;
    logic                w_rd_in_len;
    logic [ADDR_WIDTH:0] w_commit_len;
    logic [DW-1:0]       w_rd_word;

    // full_cnt alone distinguishes full from empty, since wp == rp in both cases
    assign w_wr_ready   = (r_full_cnt < NumBanksC);
    assign w_rd_valid   = (r_full_cnt != '0);
    assign w_wr_acc     = bus.wr_en && w_wr_ready;
    assign w_commit_acc = bus.wr_commit && w_wr_ready;
    assign w_rd_acc     = bus.rd_en && w_rd_valid;
    assign w_rel_acc    = bus.rd_release && w_rd_valid;
    assign w_commit_len = (bus.wr_len > LenMax) ? LenMax : bus.wr_len;
    assign w_rd_in_len  = ({1'b0, bus.rd_addr} < r_len[r_rp]);
    assign w_rd_word    = r_mem[r_rp][bus.rd_addr];

    assign bus.wr_ready = w_wr_ready;
    assign bus.wr_bank  = r_wp;
    assign bus.rd_valid = w_rd_valid;
    assign bus.rd_bank  = r_rp;
    assign bus.rd_len   = r_len[r_rp];
    assign bus.full_cnt = r_full_cnt;
    assign bus.a_vec    = r_a_vec;
    assign bus.a_valid  = r_a_valid;

    // SRAM array: byte-masked writes into the current write bank, contents not reset
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int i = 0; i < int'(TM); i++) begin
                if (bus.wr_mask[i]) begin
                    r_mem[r_wp][bus.wr_addr][i*8 +: 8] <= bus.wr_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_full_cnt <= '0;
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                r_len[b] <= '0;
            end
        end else begin
            if (w_commit_acc) begin
                r_len[r_wp] <= w_commit_len;
                r_wp        <= (r_wp == LastBank) ? '0 : r_wp + BW'(1);
            end
            if (w_rel_acc) begin
                r_rp <= (r_rp == LastBank) ? '0 : r_rp + BW'(1);
            end
            case ({w_commit_acc, w_rel_acc})
                2'b10:   r_full_cnt <= r_full_cnt + CW'(1);
                2'b01:   r_full_cnt <= r_full_cnt - CW'(1);
                default: r_full_cnt <= r_full_cnt;
            endcase
        end
    end

`ifdef ACT_BUF_OUTREG_EN
    logic          r_s1_valid;
    logic          r_s1_zero;
    logic [DW-1:0] r_s1_data;

    // Raw word and the out-of-length flag travel together; zeroing happens at the last stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_data  <= '0;
            r_a_valid  <= 1'b0;
            r_a_vec    <= '0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_word;
                r_s1_zero <= !w_rd_in_len;
            end
            r_a_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_a_vec <= r_s1_zero ? '0 : r_s1_data;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_vec   <= '0;
        end else begin
            r_a_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_a_vec <= w_rd_in_len ? w_rd_word : '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_act_buffer_nbank.sv
// Bench for act_buffer_nbank: directed table and sequences, then random traffic against
// a bank-ring reference model. Latency follows ACT_BUF_OUTREG_EN.
module tb_act_buffer_nbank;
    localparam int unsigned TM    = 8;
    localparam int unsigned AW    = 7;
    localparam int unsigned NB    = 3;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned DW    = TM * 8;
`ifdef ACT_BUF_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    act_buffer_nbank_if #(.TM(TM), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) bus ();

    act_buffer_nbank #(.TM(TM), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: banks as plain arrays, ring positions as integers mod NB
    logic [DW-1:0] m_mem [NB][DEPTH];
    int            m_len [NB];
    int            m_wp, m_rp, m_cnt;
    logic          hv [LAT];
    logic [DW-1:0] hd [LAT];
    logic          e_valid;
    logic [DW-1:0] e_vec;

    task automatic model_reset();
        m_wp = 0; m_rp = 0; m_cnt = 0;
        for (int b = 0; b < int'(NB); b++) m_len[b] = 0;
        for (int i = 0; i < LAT; i++) begin hv[i] = 1'b0; hd[i] = '0; end
        e_valid = 1'b0; e_vec = '0;
    endtask

    task automatic model_step();
        bit            can_wr, can_rd, acc;
        logic [DW-1:0] data;
        int            inc, dec;
        can_wr = (m_cnt < int'(NB));
        can_rd = (m_cnt > 0);
        acc    = bus.rd_en && can_rd;
        data   = (int'(bus.rd_addr) < m_len[m_rp]) ? m_mem[m_rp][bus.rd_addr] : '0;
        if (bus.wr_en && can_wr)
            for (int i = 0; i < int'(TM); i++)
                if (bus.wr_mask[i]) m_mem[m_wp][bus.wr_addr][i*8 +: 8] = bus.wr_data[i*8 +: 8];
        inc = 0; dec = 0;
        if (bus.wr_commit && can_wr) begin
            m_len[m_wp] = (int'(bus.wr_len) > int'(DEPTH)) ? int'(DEPTH) : int'(bus.wr_len);
            m_wp = (m_wp + 1) % int'(NB);
            inc = 1;
        end
        if (bus.rd_release && can_rd) begin
            m_rp = (m_rp + 1) % int'(NB);
            dec = 1;
        end
        m_cnt = m_cnt + inc - dec;
        for (int i = LAT - 1; i > 0; i--) begin hv[i] = hv[i-1]; hd[i] = hd[i-1]; end
        hv[0] = acc; hd[0] = data;
        e_valid = hv[LAT-1];
        if (e_valid) e_vec = hd[LAT-1];
    endtask

    task automatic idle();
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
        bus.wr_commit = 0; bus.wr_len = '0;
        bus.rd_en = 0; bus.rd_addr = '0; bus.rd_release = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk); #3;
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] data, input logic [TM-1:0] mask);
        bus.wr_en = 1; bus.wr_addr = AW'(addr); bus.wr_data = data; bus.wr_mask = mask;
        tick();
        bus.wr_en = 0;
    endtask

    task automatic commit(input int len);
        bus.wr_commit = 1; bus.wr_len = (AW+1)'(len);
        tick();
        bus.wr_commit = 0;
    endtask

    task automatic release_bank();
        bus.rd_release = 1;
        tick();
        bus.rd_release = 0;
    endtask

    // Waits out the remaining latency after the issuing tick, then checks the pulse
    task automatic expect_data(input string name, input logic [DW-1:0] exp);
        for (int k = 1; k < LAT; k++) begin
            chk({name, "_early_valid"}, bus.a_valid, 0);
            tick();
        end
        chk({name, "_valid"}, bus.a_valid, 1);
        chk({name, "_vec"}, bus.a_vec, exp);
        tick();
        chk({name, "_pulse_end"}, bus.a_valid, 0);
        chk({name, "_hold"}, bus.a_vec, exp);
    endtask

    task automatic rd_check(input string name, input int addr, input logic [DW-1:0] exp);
        bus.rd_en = 1; bus.rd_addr = AW'(addr);
        tick();
        bus.rd_en = 0;
        expect_data(name, exp);
    endtask

    typedef struct {
        logic          commit;
        logic [AW:0]   len;
        int            wb;
        int            fc;
        logic          rdy;
        int            rl;
    } vec_t;

    vec_t tab [4];

    initial begin
        tab[0] = '{1'b1, 8'd4, 1, 1, 1'b1, 4};
        tab[1] = '{1'b1, 8'd5, 2, 2, 1'b1, 4};
        tab[2] = '{1'b1, 8'd6, 0, 3, 1'b0, 4};
        tab[3] = '{1'b1, 8'd7, 0, 3, 1'b0, 4};

        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        chk("rst_wr_bank", bus.wr_bank, 0);
        chk("rst_rd_bank", bus.rd_bank, 0);
        chk("rst_full_cnt", bus.full_cnt, 0);
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_a_valid", bus.a_valid, 0);
        chk("rst_a_vec", bus.a_vec, 0);
        chk("rst_rd_len", bus.rd_len, 0);

        // Fill the ring; the fourth commit hits a full ring and is dropped
        for (int i = 0; i < 4; i++) begin
            bus.wr_commit = tab[i].commit; bus.wr_len = tab[i].len;
            tick();
            chk("t1_wr_bank", bus.wr_bank, tab[i].wb);
            chk("t1_full_cnt", bus.full_cnt, tab[i].fc);
            chk("t1_wr_ready", bus.wr_ready, tab[i].rdy);
            chk("t1_rd_len", bus.rd_len, tab[i].rl);
            chk("t1_rd_valid", bus.rd_valid, 1);
        end
        idle();
        for (int i = 0; i < 3; i++) release_bank();
        chk("t1_drain_full_cnt", bus.full_cnt, 0);
        chk("t1_drain_rd_bank", bus.rd_bank, 0);
        chk("t1_drain_rd_valid", bus.rd_valid, 0);

        // Masked overwrite of the low half
        wr(2, 64'h0807060504030201, 8'hFF);
        wr(2, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        commit(4);
        rd_check("t2", 2, 64'h08070605FFFFFFFF);

        // Length boundary inside bank 1
        release_bank();
        wr(2, 64'h1122334455667788, 8'hFF);
        wr(3, 64'hA5A5A5A5A5A5A5A5, 8'hFF);
        commit(3);
        chk("t3_rd_bank", bus.rd_bank, 1);
        chk("t3_rd_len", bus.rd_len, 3);
        rd_check("t3_oob", 3, 64'h0);
        rd_check("t3_inb", 2, 64'h1122334455667788);

        // Simultaneous commit and release with rp wrapping 2 -> 0
        release_bank();
        wr(0, 64'h0102030405060708, 8'hFF);
        commit(2);
        chk("t4_pre_rd_bank", bus.rd_bank, 2);
        chk("t4_pre_wr_bank", bus.wr_bank, 0);
        chk("t4_pre_full_cnt", bus.full_cnt, 1);
        bus.wr_commit = 1; bus.wr_len = 8'd5; bus.rd_release = 1;
        tick();
        idle();
        chk("t4_rd_bank", bus.rd_bank, 0);
        chk("t4_wr_bank", bus.wr_bank, 1);
        chk("t4_full_cnt", bus.full_cnt, 1);
        chk("t4_rd_len", bus.rd_len, 5);

        // Read and release of bank 1 in the same cycle
        wr(0, 64'hDEADBEEFCAFEF00D, 8'hFF);
        commit(2);
        release_bank();
        chk("t5_pre_rd_bank", bus.rd_bank, 1);
        bus.rd_en = 1; bus.rd_addr = '0; bus.rd_release = 1;
        tick();
        idle();
        chk("t5_rd_bank", bus.rd_bank, 2);
        chk("t5_full_cnt", bus.full_cnt, 0);
        expect_data("t5", 64'hDEADBEEFCAFEF00D);

        // Reset lands while a read is in flight
        wr(0, 64'h5A5A5A5A12345678, 8'hFF);
        commit(1);
        bus.rd_en = 1; bus.rd_addr = '0;
        tick();
        idle();
        rst_n = 1'b0;
        #2;
        chk("t6_a_valid", bus.a_valid, 0);
        chk("t6_a_vec", bus.a_vec, 0);
        chk("t6_full_cnt", bus.full_cnt, 0);
        chk("t6_wr_ready", bus.wr_ready, 1);
        chk("t6_rd_valid", bus.rd_valid, 0);
        chk("t6_wr_bank", bus.wr_bank, 0);
        model_reset();
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Prefill every word of every bank so random reads never see unwritten SRAM
        do_reset();
        for (int b = 0; b < int'(NB); b++) begin
            for (int a = 0; a < int'(DEPTH); a++) wr(a, {$urandom, $urandom}, 8'hFF);
            commit(DEPTH);
            release_bank();
        end

        for (int c = 0; c < 3000; c++) begin
            bus.wr_en      = ($urandom_range(0, 1) == 1);
            bus.wr_addr    = AW'($urandom_range(0, DEPTH - 1));
            bus.wr_data    = {$urandom, $urandom};
            bus.wr_mask    = TM'($urandom);
            bus.wr_commit  = ($urandom_range(0, 5) == 0);
            bus.wr_len     = (AW+1)'($urandom_range(0, 2 * DEPTH - 1));
            bus.rd_en      = ($urandom_range(0, 1) == 1);
            bus.rd_addr    = AW'($urandom_range(0, DEPTH - 1));
            bus.rd_release = ($urandom_range(0, 5) == 0);
            tick();
            chk("r_wr_bank", bus.wr_bank, m_wp);
            chk("r_rd_bank", bus.rd_bank, m_rp);
            chk("r_full_cnt", bus.full_cnt, m_cnt);
            chk("r_wr_ready", bus.wr_ready, m_cnt < int'(NB));
            chk("r_rd_valid", bus.rd_valid, m_cnt > 0);
            chk("r_rd_len", bus.rd_len, m_len[m_rp]);
            chk("r_a_valid", bus.a_valid, e_valid);
            chk("r_a_vec", bus.a_vec, e_vec);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
